double_to_float: RTL
====================

DOUBLE_TO_FLOAT -- requirements
Module: double_to_float

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 `clk` input 1: rising-edge clock.
REQ-004 `rst` input 1: asynchronous active-high reset.
REQ-005 `input_a` input 64: IEEE-754 binary64 operand, i.e. the `output_z` of the upstream double_multiplier.
REQ-006 `input_a_stb` input 1: upstream asserts while `input_a` is valid.
REQ-007 `input_a_ack` output 1: block is ready to accept `input_a`.
REQ-008 `output_z` output 32: IEEE-754 binary32 result.
REQ-009 `output_z_stb` output 1: `output_z` is valid.
REQ-010 `output_z_ack` input 1: downstream accepts `output_z`.

Function
REQ-011 The block SHALL convert one binary64 value to binary32 using round-to-nearest-ties-to-even, one conversion at a time.
REQ-012 The FSM SHALL have states GET_A, UNPACK, SPECIAL, DENORM, ROUND, PACK and PUT_Z.
REQ-013 GET_A SHALL hold `input_a_ack`=1 and, on a cycle with `input_a_stb`&&`input_a_ack`, capture `input_a`, drop ack on the next edge, and go to UNPACK.
REQ-014 UNPACK SHALL split sign s, 11-bit exponent e, and 52-bit fraction f, form unbiased exponent E=e-1023 and a 53-bit significand {1,f}, then go to SPECIAL.
REQ-015 SPECIAL SHALL produce results as follows, then go to PUT_Z:
- e=0x7FF and f!=0: output {s,8'hFF,1'b1,22'b0}.
- e=0x7FF and f=0: output {s,8'hFF,23'b0}.
- e=0 (zero or double denormal): output {s,31'b0}.
- E>127: output {s,8'hFF,23'b0}.
- E<-150: output {s,31'b0}.
REQ-016 For any other value, SPECIAL SHALL keep a 24-bit mantissa plus guard, round and sticky bits (sticky = OR of the discarded fraction bits), then go to DENORM.
REQ-017 DENORM SHALL, while E<-126, shift the mantissa/guard/round/sticky right by 1 per clock, OR-ing into sticky, and increment E; when E>=-126 it SHALL go to ROUND.
REQ-018 DENORM SHALL take at most 24 cycles.
REQ-019 ROUND SHALL increment the mantissa when guard && (round || sticky || mantissa[0]).
REQ-020 If rounding overflows 24 bits, ROUND SHALL set the mantissa to 24'h800000 and increment E.
REQ-021 PACK SHALL form the result as follows:
- E=-126 and mantissa[23]=0: biased exponent 0 (subnormal).
- Otherwise: biased exponent E+127.
- E>127 after rounding: output {s,8'hFF,23'b0}.
REQ-022 PACK SHALL take fraction = mantissa[22:0] and then go to PUT_Z.
REQ-023 PUT_Z SHALL assert `output_z_stb`=1 and hold `output_z` stable until `output_z_ack`=1 is sampled.
REQ-024 On that `output_z_ack` edge PUT_Z SHALL drop stb and return to GET_A.
REQ-025 `input_a_stb` SHALL be ignored in every state except GET_A.
REQ-026 `input_a_ack` and `output_z_stb` SHALL never be high in the same cycle.
REQ-027 Latency from the capture edge to first `output_z_stb` SHALL be 5 cycles for normal results and 5+k cycles for subnormal results, where k is the DENORM shift count.
REQ-028 Latency for special-case results SHALL be 3 cycles.
REQ-029 If `output_z_ack` is already high on entry to PUT_Z, stb SHALL still be high for exactly one cycle.

Reset
REQ-030 Asserting `rst` SHALL, asynchronously and in any state including mid-conversion or DENORM, force state=GET_A, `input_a_ack`=0, `output_z_stb`=0, `output_z`=32'h0, and discard all internal data.
REQ-031 `input_a_ack` SHALL rise on the first clock edge after `rst` deasserts.
REQ-032 No stale result SHALL be emitted after reset.

Verification
REQ-033 Normal cases SHALL be covered:
- 64'h3FF0000000000000 -> 32'h3F800000.
- 64'hC004000000000000 -> 32'hC0200000.
- Both with stb at 5 cycles.
REQ-034 Rounding SHALL be covered:
- 64'h3FF0000010000000 (tie) -> 32'h3F800000.
- 64'h3FF0000010000001 -> 32'h3F800001.
- 64'h3FEFFFFFF0000000 -> 32'h3F800000 (round carry).
REQ-035 Specials SHALL be covered:
- 64'h7FF8000000000000 -> 32'h7FC00000.
- 64'hFFF0000000000000 -> 32'hFF800000.
- 64'h7E37E43C8800759C -> 32'h7F800000.
- 64'h8000000000000001 -> 32'h80000000.
REQ-036 Subnormals SHALL be covered:
- 64'h36A0000000000000 -> 32'h00000001.
- 64'h3800000000000000 -> 32'h00400000.
- 64'h3690000000000000 -> 32'h00000000.
REQ-037 Backpressure SHALL be covered: hold `output_z_ack`=0 for 10 cycles, and check `output_z` is stable, `input_a_ack`=0, and a new `input_a_stb` is not captured; raise ack and check stb drops and the next operand is accepted.
REQ-038 Reset mid-DENORM SHALL be covered: assert `rst` during 64'h36A0000000000000 processing, and check stb/ack immediately 0, `output_z`=0; after release, 64'h3FF0000000000000 -> 32'h3F800000.

Source files
------------

// File: rtl/double_to_float.sv
// double_to_float
//   Converts one IEEE-754 binary64 operand to binary32 using
//   round-to-nearest, ties-to-even. Conversions are handled one at a time
//   under a stb/ack handshake on each side.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   input_a       binary64 operand
//   input_a_stb   upstream: input_a is valid
//   input_a_ack   block is ready to take input_a
//   output_z      binary32 result
//   output_z_stb  output_z is valid
//   output_z_ack  downstream accepts output_z
module double_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        SPECIAL,
        DENORM,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        a_q, a_d;
    logic               s_q, s_d;
    logic [10:0]        eraw_q, eraw_d;
    logic [51:0]        f_q, f_d;
    logic signed [11:0] exp_q, exp_d;
    logic [23:0]        m_q, m_d;
    logic               g_q, g_d;
    logic               r_q, r_d;
    logic               st_q, st_d;
    logic               special_q, special_d;
    logic [31:0]        z_q, z_d;
    logic               ack_q, ack_d;
    logic               stb_q, stb_d;

    logic [52:0]        sig;
    logic [7:0]         biased;

    assign input_a_ack  = ack_q;
    assign output_z_stb = stb_q;
    assign output_z     = z_q;

    // Significand with the hidden one restored.
    assign sig    = {1'b1, f_q};
    // Only evaluated when exp_q is within [-126,127], so the low byte of the
    // biased exponent is exact.
    assign biased = exp_q[7:0] + 8'd127;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= GET_A;
            a_q       <= 64'h0;
            s_q       <= 1'b0;
            eraw_q    <= 11'h0;
            f_q       <= 52'h0;
            exp_q     <= 12'sd0;
            m_q       <= 24'h0;
            g_q       <= 1'b0;
            r_q       <= 1'b0;
            st_q      <= 1'b0;
            special_q <= 1'b0;
            z_q       <= 32'h0;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            s_q       <= s_d;
            eraw_q    <= eraw_d;
            f_q       <= f_d;
            exp_q     <= exp_d;
            m_q       <= m_d;
            g_q       <= g_d;
            r_q       <= r_d;
            st_q      <= st_d;
            special_q <= special_d;
            z_q       <= z_d;
            ack_q     <= ack_d;
            stb_q     <= stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        s_d       = s_q;
        eraw_d    = eraw_q;
        f_d       = f_q;
        exp_d     = exp_q;
        m_d       = m_q;
        g_d       = g_q;
        r_d       = r_q;
        st_d      = st_q;
        special_d = special_q;
        z_d       = z_q;
        ack_d     = 1'b0;
        stb_d     = 1'b0;

        case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (input_a_stb && ack_q) begin
                    a_d     = input_a;
                    ack_d   = 1'b0;
                    state_d = UNPACK;
                end
            end

            UNPACK: begin
                s_d     = a_q[63];
                eraw_d  = a_q[62:52];
                f_d     = a_q[51:0];
                exp_d   = $signed({1'b0, a_q[62:52]}) - 12'sd1023;
                state_d = SPECIAL;
            end

            // Special results are parked in z and walked through PACK so the
            // special path has a fixed three-cycle latency.
            SPECIAL: begin
                special_d = 1'b1;
                state_d   = PACK;
                if (eraw_q == 11'h7FF && f_q != 52'h0) begin
                    z_d = {s_q, 8'hFF, 1'b1, 22'h0};
                end else if (eraw_q == 11'h7FF) begin
                    z_d = {s_q, 8'hFF, 23'h0};
                end else if (eraw_q == 11'h0) begin
                    z_d = {s_q, 31'h0};
                end else if (exp_q > 12'sd127) begin
                    z_d = {s_q, 8'hFF, 23'h0};
                end else if (exp_q < -12'sd150) begin
                    z_d = {s_q, 31'h0};
                end else begin
                    special_d = 1'b0;
                    m_d       = sig[52:29];
                    g_d       = sig[28];
                    r_d       = sig[27];
                    st_d      = |sig[26:0];
                    state_d   = DENORM;
                end
            end

            // One bit per clock until the exponent reaches the subnormal
            // floor; bits falling off the round position fold into sticky.
            DENORM: begin
                if (exp_q < -12'sd126) begin
                    m_d   = {1'b0, m_q[23:1]};
                    g_d   = m_q[0];
                    r_d   = g_q;
                    st_d  = st_q | r_q;
                    exp_d = exp_q + 12'sd1;
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                if (g_q && (r_q || st_q || m_q[0])) begin
                    if (m_q == 24'hFFFFFF) begin
                        m_d   = 24'h800000;
                        exp_d = exp_q + 12'sd1;
                    end else begin
                        m_d = m_q + 24'd1;
                    end
                end
                state_d = PACK;
            end

            PACK: begin
                if (!special_q) begin
                    if (exp_q > 12'sd127) begin
                        z_d = {s_q, 8'hFF, 23'h0};
                    end else if (exp_q == -12'sd126 && !m_q[23]) begin
                        z_d = {s_q, 8'h00, m_q[22:0]};
                    end else begin
                        z_d = {s_q, biased, m_q[22:0]};
                    end
                end
                stb_d   = 1'b1;
                state_d = PUT_Z;
            end

            PUT_Z: begin
                if (output_z_ack) begin
                    ack_d   = 1'b1;
                    state_d = GET_A;
                end else begin
                    stb_d = 1'b1;
                end
            end

            default: begin
                state_d = GET_A;
            end
        endcase
    end

endmodule
